// File: rtl/morph_pkg.sv
// Shared types and helpers for the morph_unit grayscale morphology stage.
package morph_pkg;

  typedef enum logic {
    MORPH_ERODE  = 1'b0,
    MORPH_DILATE = 1'b1
  } morph_mode_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_OUT
  } morph_state_t;

  // Wide signed carrier so the helpers work for any accumulator width up to 63 bits.
  localparam int MORPH_MAX_W = 64;
  typedef logic signed [MORPH_MAX_W-1:0] morph_wide_t;

  // Largest value of a w-bit signed number: erosion accumulator start value.
  function automatic morph_wide_t morph_acc_max(input int w);
    return (morph_wide_t'(1) <<< (w - 1)) - morph_wide_t'(1);
  endfunction

  // Smallest value of a w-bit signed number: dilation accumulator start value.
  function automatic morph_wide_t morph_acc_min(input int w);
    return -(morph_wide_t'(1) <<< (w - 1));
  endfunction

  // Clamp a wide signed value into the signed range of a dw-bit sample.
  function automatic morph_wide_t morph_sat(input morph_wide_t v, input int dw);
    morph_wide_t hi;
    morph_wide_t lo;
    hi = morph_acc_max(dw);
    lo = morph_acc_min(dw);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/morph_unit_window.sv
// Sample window for morph_unit: newest-first shift register, saturating fill
// counter with end-of-record clear, and a combinational indexed read port.
module morph_window #(
  parameter int DATA_WIDTH   = 16,
  parameter int KERNEL_WIDTH = 71,
  parameter int IDX_W        = $clog2(KERNEL_WIDTH),
  parameter int FILL_W       = $clog2(KERNEL_WIDTH + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         clear,
  input  logic signed [DATA_WIDTH-1:0] din,
  input  logic        [IDX_W-1:0]      rd_idx,
  output logic signed [DATA_WIDTH-1:0] rd_data,
  output logic        [FILL_W-1:0]     fill
);

  logic signed [DATA_WIDTH-1:0] taps [KERNEL_WIDTH];

  // Shift the new sample into tap 0 and track how many taps hold record data.
  // NOTE: sequential state uses non-blocking assignments so every tap reads the
  // pre-edge value of its neighbour; blocking here would collapse the shift chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the taps are reset because the window must come up cleared; a
      // plain data memory with no such need would normally be left unreset.
      for (int i = 0; i < KERNEL_WIDTH; i++) taps[i] <= '0;
      fill <= '0;
    end else begin
      if (push) begin
        taps[0] <= din;
        for (int i = 1; i < KERNEL_WIDTH; i++) taps[i] <= taps[i-1];
        if (fill != FILL_W'(KERNEL_WIDTH)) fill <= fill + FILL_W'(1);
      end
      if (clear) fill <= '0;
    end
  end

  // Indexed read; the caller only presents indices below KERNEL_WIDTH.
  assign rd_data = taps[rd_idx];

endmodule

// File: rtl/morph_unit.sv
// morph_unit: one erosion (mode=0) or dilation (mode=1) per input sample over a
// partial-then-full window, kernel taps fetched from a registered external LUT.
// Build option: define MORPH_SATURATE_EN to clamp results to the sample range;
// otherwise the low DATA_WIDTH bits are kept (two's-complement wrap).
module morph_unit
  import morph_pkg::*;
#(
  parameter int DATA_WIDTH        = 16,
  parameter int KERNEL_WIDTH      = 71,
  parameter int KERNEL_DATA_WIDTH = 8,
  parameter int INTERNAL_WIDTH    = 17
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                mode,
  input  logic signed [DATA_WIDTH-1:0]        axis_in_tdata,
  input  logic                                axis_in_tvalid,
  input  logic                                axis_in_tlast,
  output logic                                axis_in_tready,
  output logic signed [DATA_WIDTH-1:0]        axis_out_tdata,
  output logic                                axis_out_tvalid,
  output logic                                axis_out_tlast,
  input  logic                                axis_out_tready,
  output logic [$clog2(KERNEL_WIDTH)-1:0]     kernel_lut_address,
  input  logic signed [KERNEL_DATA_WIDTH-1:0] kernel_lut_data
);

  localparam int AW = $clog2(KERNEL_WIDTH);
  localparam int FW = $clog2(KERNEL_WIDTH + 1);
  localparam int IW = INTERNAL_WIDTH;

  localparam morph_wide_t ACC_MAX_W = morph_acc_max(IW);
  localparam morph_wide_t ACC_MIN_W = morph_acc_min(IW);
  localparam logic signed [IW-1:0] ACC_MAX = ACC_MAX_W[IW-1:0];
  localparam logic signed [IW-1:0] ACC_MIN = ACC_MIN_W[IW-1:0];

  morph_state_t                 state;
  morph_mode_t                  mode_q;
  logic                         last_q;
  logic        [FW-1:0]         cnt;    // SCAN cycle index; LUT word for tap cnt-1 arrives now
  logic        [AW-1:0]         tap_d;  // address presented last cycle
  logic signed [IW-1:0]         acc;
  logic signed [IW-1:0]         acc_next;
  logic signed [IW-1:0]         w_ext;
  logic signed [IW-1:0]         k_ext;
  logic signed [IW-1:0]         cand;
  logic signed [DATA_WIDTH-1:0] result;
  logic signed [DATA_WIDTH-1:0] win_data;
  logic        [FW-1:0]         fill;
  logic                         in_hs;
  logic                         out_hs;

  assign in_hs  = (state == S_IDLE) && axis_in_tready && axis_in_tvalid;
  assign out_hs = (state == S_OUT) && axis_out_tvalid && axis_out_tready;

  morph_window #(
    .DATA_WIDTH  (DATA_WIDTH),
    .KERNEL_WIDTH(KERNEL_WIDTH)
  ) u_window (
    .clk    (clk),
    .rst    (rst),
    .push   (in_hs),
    .clear  (out_hs && last_q),
    .din    (axis_in_tdata),
    .rd_idx (tap_d),
    .rd_data(win_data),
    .fill   (fill)
  );

`ifdef MORPH_SATURATE_EN
  morph_wide_t sat_w;
`endif

  // Combine the arriving LUT word with its window tap and fold it into the running min/max.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    acc_next = acc;
    w_ext    = {{(IW - DATA_WIDTH){win_data[DATA_WIDTH-1]}}, win_data};
    k_ext    = {{(IW - KERNEL_DATA_WIDTH){kernel_lut_data[KERNEL_DATA_WIDTH-1]}}, kernel_lut_data};
    cand     = (mode_q == MORPH_DILATE) ? (w_ext + k_ext) : (w_ext - k_ext);
    if (mode_q == MORPH_DILATE) begin
      if (cand > acc) acc_next = cand;
    end else begin
      if (cand < acc) acc_next = cand;
    end
  end

  // Narrow the accumulator to the output sample width.
  always_comb begin
`ifdef MORPH_SATURATE_EN
    sat_w  = morph_sat(morph_wide_t'(acc_next), DATA_WIDTH);
    result = sat_w[DATA_WIDTH-1:0];
`else
    result = acc_next[DATA_WIDTH-1:0];
`endif
  end

  // Control FSM: accept a sample, scan taps 0..f-1 through the LUT, hold the result until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= S_IDLE;
      axis_in_tready     <= 1'b0;
      axis_out_tvalid    <= 1'b0;
      axis_out_tdata     <= '0;
      axis_out_tlast     <= 1'b0;
      kernel_lut_address <= '0;
      cnt                <= '0;
      tap_d              <= '0;
      acc                <= '0;
      mode_q             <= MORPH_ERODE;
      last_q             <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (axis_in_tready && axis_in_tvalid) begin
            axis_in_tready     <= 1'b0;
            mode_q             <= morph_mode_t'(mode);
            last_q             <= axis_in_tlast;
            acc                <= mode ? ACC_MIN : ACC_MAX;
            kernel_lut_address <= '0;
            cnt                <= '0;
            state              <= S_SCAN;
          end else begin
            axis_in_tready <= 1'b1;
          end
        end
        S_SCAN: begin
          tap_d <= kernel_lut_address;
          cnt   <= cnt + FW'(1);
          if (cnt != '0) acc <= acc_next;
          if (int'(cnt) + 1 < int'(fill)) kernel_lut_address <= AW'(cnt + FW'(1));
          else                            kernel_lut_address <= '0;
          if (cnt == fill) begin
            axis_out_tvalid <= 1'b1;
            axis_out_tdata  <= result;
            axis_out_tlast  <= last_q;
            state           <= S_OUT;
          end
        end
        S_OUT: begin
          if (axis_out_tready) begin
            axis_out_tvalid <= 1'b0;
            axis_in_tready  <= 1'b1;
            state           <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/morph_unit.md
# morph_unit

Runtime-selectable grayscale morphology stage for 1-D signed sample streams. It computes one erosion or one dilation per input sample against a kernel read from an external LUT. It is the next-generation building block for the open/close/lower/upper filter chains: any of those chains is built by cascading `morph_unit` instances with per-instance `mode`. It adds record boundaries (`tlast`), partial-window handling at record start, and optional output saturation.

## Interface
- `DATA_WIDTH`, 16, signed sample width.
- `KERNEL_WIDTH`, 71, kernel taps; must be ≥ 2.
- `KERNEL_DATA_WIDTH`, 8, signed kernel coefficient width.
- `INTERNAL_WIDTH`, 17, accumulator width; must be ≥ max(`DATA_WIDTH`, `KERNEL_DATA_WIDTH`) + 1.
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `mode`  in  1  0 = erode, 1 = dilate; sampled at the input handshake.
- `axis_in_tdata`  in  `DATA_WIDTH`  signed input sample.
- `axis_in_tvalid`  in  1  input valid.
- `axis_in_tlast`  in  1  last sample of the record.
- `axis_in_tready`  out  1  input ready.
- `axis_out_tdata`  out  `DATA_WIDTH`  signed result.
- `axis_out_tvalid`  out  1  output valid.
- `axis_out_tlast`  out  1  copy of the input `tlast` for this result.
- `axis_out_tready`  in  1  output ready.
- `kernel_lut_address`  out  $clog2(`KERNEL_WIDTH`)  tap index k.
- `kernel_lut_data`  in  `KERNEL_DATA_WIDTH`  signed K[k]; valid one cycle after the address is presented (registered ROM).

## Operation
- Window: w[0] holds the newest sample, w[k] = x[n−k]. The fill count f saturates at `KERNEL_WIDTH`. Only taps k < f take part in the reduction.
- Erode: y = min over k<f of (w[k] − K[k]).
- Dilate: y = max over k<f of (w[k] + K[k]).
- Arithmetic: w and K are sign-extended to `INTERNAL_WIDTH`. The accumulator initialises to the INTERNAL max (erode) or the INTERNAL min (dilate).
- FSM states:
  - IDLE: `axis_in_tready`=1. On handshake: shift the sample in, set f=min(f+1, K), latch `mode` and `tlast`, go to SCAN.
  - SCAN: the address steps 0..f−1, one per cycle. Each LUT word is combined with w[k] using a one-cycle-delayed index. After the last product, go to OUT.
  - OUT: `axis_out_tvalid`=1. `tdata` and `tlast` are held stable until the handshake, then go to IDLE. If the latched `tlast` was 1, f is cleared to 0 in that same handshake cycle.
- `kernel_lut_address` = 0 outside SCAN.
- Changes to `mode` or the LUT during SCAN/OUT do not affect the result in flight.
- Reset values: `axis_in_tready`=0, `axis_out_tvalid`=0, `axis_out_tdata`=0, `axis_out_tlast`=0, `kernel_lut_address`=0. Window cleared, f=0, state IDLE. `axis_in_tready` goes to 1 in the first cycle after `rst` deasserts.
- `rst` asserted mid-SCAN or mid-OUT aborts the operation. The pending result is discarded, and `tvalid` is 0 from the next cycle.

## Timing
- With the input handshake in cycle T, `axis_out_tvalid` rises in cycle T+f+2, where f is the post-increment fill count.
  - First sample of a record: T+3.
  - Full window: T+`KERNEL_WIDTH`+2.
- `axis_in_tready` is low from T+1 until the cycle after the output handshake.
- Sustained throughput with `axis_out_tready`=1: one sample per f+3 cycles, i.e. `KERNEL_WIDTH`+3 in steady state.
- Backpressure: OUT is held indefinitely. No input is accepted and no LUT reads occur.

## Configuration
- Macro `MORPH_SATURATE_EN`.
  - Defined: the INTERNAL result is clamped to the signed `DATA_WIDTH` range [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1].
  - Undefined: the low `DATA_WIDTH` bits are taken (two's-complement wrap).

## Structure
- Package `morph_pkg`:
  - `morph_mode_t` enum {MORPH_ERODE=0, MORPH_DILATE=1}.
  - `morph_state_t` enum {S_IDLE, S_SCAN, S_OUT}.
  - `morph_sat` function (INTERNAL→DATA clamp).
  - Accumulator init constants.
- Sub-module `morph_window`: shift register with fill counter, tlast-driven clear, and indexed read port. The FSM, accumulator and output register stay in `morph_unit`.

## Test plan
- K=3, LUT {0,0,0}, erode, inputs 5,2,7,9 -> outputs 5,2,2,2.
- K=3, LUT {0,1,2}, dilate, inputs 10,0,0 -> outputs 10,11,12.
- DATA_WIDTH=16, dilate, LUT[0]=5, first sample 32767 -> output 32767 with `MORPH_SATURATE_EN`; −32764 without.
- K=3, zero LUT, erode, inputs 1, 2 (tlast), 9 -> outputs 1, 1 (tlast=1), 9.
- K=71, `axis_out_tready` held low 10 cycles after the first full-window result -> `tvalid` rises at T+73, `tdata` stable, `axis_in_tready`=0 throughout.
- `rst` pulsed for 1 cycle mid-SCAN -> `tvalid` never asserts for that sample. The next sample is treated as a record start (output = sample − K[0] for erode).
